// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM driving the ULA/register/memory datapath,
// with branch PCWrite resolved combinationally from the ULA zero flag.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC + 4
// DECODE   | read registers, precompute branch target into ULAOut
// MEMADR   | compute load/store address A + imm
// MEMREAD  | read data memory at ULAOut
// MEMWB    | write loaded data to register file
// MEMWRITE | write RD2 to data memory at ULAOut
// EXECR    | R-type ULA operation A op RD2
// EXECI    | I-type ULA operation A op imm
// ULAWB    | write ULAOut to register file
// JAL      | PC <= target, ULAOut <= OldPC + 4 (link value)
// BRANCH   | compare A - RD2, conditionally load PC from ULAOut
module unidade_controle_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Z,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ULAControl,
    output logic       Ilegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ULAWB, S_JAL, S_BRANCH
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SUB = 4'b0001;
    localparam logic [3:0] ULA_AND = 4'b0010;
    localparam logic [3:0] ULA_OR  = 4'b0011;
    localparam logic [3:0] ULA_SLT = 4'b0101;
    localparam logic [3:0] ULA_XOR = 4'b0111;
    localparam logic [3:0] ULA_SRL = 4'b1000;

    state_t     state, state_nxt;
    logic [3:0] alu_op;
    logic       alu_bad;
    logic       pc_w, mem_w, ir_w, reg_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        alu_op  = ULA_ADD;
        alu_bad = 1'b0;
        case (funct3)
            3'b000:  alu_op = (op == OP_R && funct7b5) ? ULA_SUB : ULA_ADD;
            3'b010:  alu_op = ULA_SLT;
            3'b100:  alu_op = ULA_XOR;
            3'b101:  if (!funct7b5) alu_op = ULA_SRL; else alu_bad = 1'b1;
            3'b110:  alu_op = ULA_OR;
            3'b111:  alu_op = ULA_AND;
            default: alu_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BR:        state_nxt = S_BRANCH;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:         state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:        state_nxt = S_MEMWB;
            S_EXECR, S_EXECI: state_nxt = alu_bad ? S_FETCH : S_ULAWB;
            S_JAL:            state_nxt = S_ULAWB;
            default:          state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ULASrcA    = 2'b00;
        ULASrcB    = 2'b00;
        ULAControl = ULA_ADD;
        Ilegal     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ULASrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ULASrcA = 2'b01;
                ULASrcB = 2'b01;
                Ilegal  = !(op == OP_LW || op == OP_SW || op == OP_R ||
                            op == OP_I  || op == OP_JAL || op == OP_BR);
            end
            S_MEMADR: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ULASrcA    = 2'b10;
                ULASrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                ULAControl = alu_bad ? ULA_ADD : alu_op;
                Ilegal     = alu_bad;
            end
            S_ULAWB:    reg_w = 1'b1;
            S_JAL: begin
                ULASrcA = 2'b01;
                ULASrcB = 2'b10;
                pc_w    = 1'b1;
            end
            S_BRANCH: begin
                ULASrcA    = 2'b10;
                ULAControl = ULA_SUB;
                case (funct3)
                    3'b000:  pc_w   = Z;
                    3'b001:  pc_w   = !Z;
                    default: Ilegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = pc_w  & ~reset;
    assign MemWrite = mem_w & ~reset;
    assign IRWrite  = ir_w  & ~reset;
    assign RegWrite = reg_w & ~reset;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit: walks each instruction class
// cycle by cycle and compares the full output vector against hand-built values.
module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Z;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Ilegal;
    logic [1:0] ResultSrc, ULASrcA, ULASrcB, ImmSrc;
    logic [3:0] ULAControl;
    logic [17:0] obs;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    unidade_controle_multiciclo dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
        .ImmSrc(ImmSrc), .ULAControl(ULAControl), .Ilegal(Ilegal)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ULASrcA, ULASrcB, ImmSrc, ULAControl, Ilegal};

    function automatic logic [17:0] sig(input logic pcw, adr, mw, irw, rw,
                                        input logic [1:0] res, sa, sb, imm,
                                        input logic [3:0] ctl, input logic il);
        return {pcw, adr, mw, irw, rw, res, sa, sb, imm, ctl, il};
    endfunction

    function automatic logic [17:0] fetch_sig(input logic [1:0] imm);
        return sig(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 0);
    endfunction

    function automatic logic [17:0] decode_sig(input logic [1:0] imm, input logic il);
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, il);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] ctl, input logic bad);
        op = o; funct3 = f3; funct7b5 = f7; #1;
        chk({tag, "/fetch"}, obs, fetch_sig(2'b00)); nxt();
        chk({tag, "/decode"}, obs, decode_sig(2'b00, 0)); nxt();
        chk({tag, "/exec"}, obs, sig(0, 0, 0, 0, 0, 2'b00, 2'b10,
                                     (o == OP_R) ? 2'b00 : 2'b01, 2'b00, ctl, bad));
        nxt();
        if (!bad) begin
            chk({tag, "/ulawb"}, obs, sig(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0));
            nxt();
        end
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3,
                          input logic pcw_z0, input logic pcw_z1, input logic il);
        op = OP_BR; funct3 = f3; funct7b5 = 0; Z = 0; #1;
        chk({tag, "/fetch"}, obs, fetch_sig(2'b10)); nxt();
        chk({tag, "/decode"}, obs, decode_sig(2'b10, 0)); nxt();
        Z = 0; #1;
        chk({tag, "/z0"}, obs, sig(pcw_z0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001, il));
        Z = 1; #1;
        chk({tag, "/z1"}, obs, sig(pcw_z1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001, il));
        nxt();
    endtask

    initial begin
        reset = 1; op = OP_LW; funct3 = 3'b010; funct7b5 = 0; Z = 0;
        @(negedge clk); #1;
        chk("rst_hold", obs, sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0));
        reset = 0;

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        #1; chk("lw/fetch", obs, fetch_sig(2'b00)); nxt();
        chk("lw/decode", obs, decode_sig(2'b00, 0)); nxt();
        chk("lw/memadr", obs, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000, 0)); nxt();
        chk("lw/memread", obs, sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0)); nxt();
        chk("lw/memwb", obs, sig(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 0)); nxt();

        // sw: FETCH DECODE MEMADR MEMWRITE
        op = OP_SW; #1;
        chk("sw/fetch", obs, fetch_sig(2'b01)); nxt();
        chk("sw/decode", obs, decode_sig(2'b01, 0)); nxt();
        chk("sw/memadr", obs, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0000, 0)); nxt();
        chk("sw/memwrite", obs, sig(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 0)); nxt();

        run_alu("r_add",  OP_R, 3'b000, 0, 4'b0000, 0);
        run_alu("r_sub",  OP_R, 3'b000, 1, 4'b0001, 0);
        run_alu("r_slt",  OP_R, 3'b010, 0, 4'b0101, 0);
        run_alu("r_xor",  OP_R, 3'b100, 0, 4'b0111, 0);
        run_alu("r_srl",  OP_R, 3'b101, 0, 4'b1000, 0);
        run_alu("r_sra",  OP_R, 3'b101, 1, 4'b0000, 1);
        run_alu("r_or",   OP_R, 3'b110, 0, 4'b0011, 0);
        run_alu("r_and",  OP_R, 3'b111, 0, 4'b0010, 0);
        run_alu("r_sll",  OP_R, 3'b001, 0, 4'b0000, 1);
        run_alu("i_addi", OP_I, 3'b000, 1, 4'b0000, 0);
        run_alu("i_xori", OP_I, 3'b100, 0, 4'b0111, 0);
        run_alu("i_srai", OP_I, 3'b101, 1, 4'b0000, 1);
        run_alu("i_sltu", OP_I, 3'b011, 0, 4'b0000, 1);

        run_br("beq",   3'b000, 0, 1, 0);
        run_br("bne",   3'b001, 1, 0, 0);
        run_br("b_bad", 3'b010, 0, 0, 1);

        // undefined opcode: FETCH DECODE(illegal) then FETCH
        op = 7'b1111111; #1;
        chk("undef/fetch", obs, fetch_sig(2'b00)); nxt();
        chk("undef/decode", obs, decode_sig(2'b00, 1)); nxt();

        // jal: FETCH DECODE JAL ULAWB
        op = OP_JAL; #1;
        chk("jal/fetch", obs, fetch_sig(2'b11)); nxt();
        chk("jal/decode", obs, decode_sig(2'b11, 0)); nxt();
        chk("jal/jal", obs, sig(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 4'b0000, 0)); nxt();
        chk("jal/ulawb", obs, sig(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 0)); nxt();

        // reset asserted in MEMREAD, held two cycles
        op = OP_LW; funct3 = 3'b010; #1;
        chk("rlw/fetch", obs, fetch_sig(2'b00)); nxt();
        chk("rlw/decode", obs, decode_sig(2'b00, 0)); nxt();
        chk("rlw/memadr", obs, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000, 0)); nxt();
        chk("rlw/memread", obs, sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0));
        reset = 1; #1;
        chk("rlw/rst0", obs, sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0)); nxt();
        chk("rlw/rst1", obs, sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0)); nxt();
        chk("rlw/rst2", obs, sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0));
        reset = 0; #1;
        chk("rlw/refetch", obs, fetch_sig(2'b00)); nxt();
        chk("rlw/redecode", obs, decode_sig(2'b00, 0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
